demux_bus_1_in_n_out: RTL and testbench

DEMUX_BUS_1_IN_N_OUT -- requirements
Module: demux_bus_1_in_N_out

---
 rtl/demux_bus_1_in_n_out_if.sv | 44 ++++
 rtl/demux_bus_1_in_n_out.sv | 146 ++++++++++++++
 tb/tb_demux_bus_1_in_n_out.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_bus_1_in_n_out_if.sv
// Signal bundle for the 1-to-N bus demux: upstream handshake, per-port outputs
// with their ready inputs, and the bad-select drop counter.
interface demux_bus_1_in_n_out_if #(
    parameter int WIDTH          = 2,
    parameter int SELECT_WIDTH   = $clog2(WIDTH),
    parameter int BUS_WIDTH      = 8,
    parameter int DROP_CNT_WIDTH = 16
);
    logic                      demux_bus_valid;
    logic [BUS_WIDTH-1:0]      demux_bus_in;
    logic [SELECT_WIDTH-1:0]   demux_select;
    logic                      demux_broadcast;
    logic                      demux_bus_ready;
    logic [WIDTH-1:0]          demux_bus_valid_out;
    logic [BUS_WIDTH-1:0]      demux_bus_out [WIDTH-1:0];
    logic [WIDTH-1:0]          demux_bus_ready_in;
    logic [DROP_CNT_WIDTH-1:0] demux_drop_count;

    // Upstream producer / downstream consumers side.
    modport master (
        output demux_bus_valid,
        output demux_bus_in,
        output demux_select,
        output demux_broadcast,
        input  demux_bus_ready,
        input  demux_bus_valid_out,
        input  demux_bus_out,
        output demux_bus_ready_in,
        input  demux_drop_count
    );

    // Demux side.
    modport slave (
        input  demux_bus_valid,
        input  demux_bus_in,
        input  demux_select,
        input  demux_broadcast,
        output demux_bus_ready,
        output demux_bus_valid_out,
        output demux_bus_out,
        input  demux_bus_ready_in,
        output demux_drop_count
    );
endinterface

// File: rtl/demux_bus_1_in_n_out.sv
// 1-to-N bus demux: a one-entry hold stage steers each word (or broadcasts it)
// into per-port 2-deep FIFOs; words with an out-of-range select are counted and dropped.
module demux_bus_1_in_n_out #(
    parameter int WIDTH          = 2,
    parameter int SELECT_WIDTH   = $clog2(WIDTH),
    parameter int BUS_WIDTH      = 8,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                    ap_clk,
    input  logic                    areset_n,
    demux_bus_1_in_n_out_if.slave   bus
);
    logic                      hold_valid_q, hold_valid_d;
    logic [BUS_WIDTH-1:0]      hold_data_q,  hold_data_d;
    logic [SELECT_WIDTH-1:0]   hold_sel_q,   hold_sel_d;
    logic                      hold_bcast_q, hold_bcast_d;
    logic                      init_q;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q,   drop_cnt_d;

    logic [WIDTH-1:0] sel_hit;
    logic [WIDTH-1:0] fifo_room;
    logic [WIDTH-1:0] push;
    logic             sel_oob;
    logic             drain;
    logic             drop;
    logic             ready;
    logic             accept;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_sel
            assign sel_hit[gi] = (hold_sel_q == SELECT_WIDTH'(gi));
        end
    endgenerate

    // Drain looks only at registered occupancy, so a pop on a full FIFO
    // frees the slot one edge later and ready never sees ready_in.
    always_comb begin
        sel_oob = ~|sel_hit;
        drain   = 1'b0;
        drop    = 1'b0;
        if (hold_valid_q) begin
            if (hold_bcast_q) begin
                drain = &fifo_room;
            end else if (sel_oob) begin
                drain = 1'b1;
                drop  = 1'b1;
            end else begin
                drain = |(sel_hit & fifo_room);
            end
        end
        ready  = init_q & (~hold_valid_q | drain);
        accept = ready & bus.demux_bus_valid;
        push   = '0;
        if (drain && !drop) begin
            push = hold_bcast_q ? {WIDTH{1'b1}} : sel_hit;
        end
    end

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_sel_d   = hold_sel_q;
        hold_bcast_d = hold_bcast_q;
        drop_cnt_d   = drop_cnt_q;
        if (accept) begin
            hold_valid_d = 1'b1;
            hold_data_d  = bus.demux_bus_in;
            hold_sel_d   = bus.demux_select;
            hold_bcast_d = bus.demux_broadcast;
        end else if (drain) begin
            hold_valid_d = 1'b0;
        end
        if (drop && (drop_cnt_q != {DROP_CNT_WIDTH{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge ap_clk or negedge areset_n) begin
        if (!areset_n) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_sel_q   <= '0;
            hold_bcast_q <= 1'b0;
            init_q       <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_sel_q   <= hold_sel_d;
            hold_bcast_q <= hold_bcast_d;
            init_q       <= 1'b1;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign bus.demux_bus_ready  = ready;
    assign bus.demux_drop_count = drop_cnt_q;

    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_port
            logic [BUS_WIDTH-1:0] ent0_q, ent1_q;
            logic                 rd_ptr_q, wr_ptr_q;
            logic [1:0]           occ_q, occ_d;
            logic                 pop;

            assign fifo_room[gi] = (occ_q != 2'd2);
            assign pop           = (occ_q != 2'd0) & bus.demux_bus_ready_in[gi];

            always_comb begin
                occ_d = occ_q;
                case ({push[gi], pop})
                    2'b10:   occ_d = occ_q + 2'd1;
                    2'b01:   occ_d = occ_q - 2'd1;
                    default: occ_d = occ_q;
                endcase
            end

            always_ff @(posedge ap_clk or negedge areset_n) begin
                if (!areset_n) begin
                    ent0_q   <= '0;
                    ent1_q   <= '0;
                    rd_ptr_q <= 1'b0;
                    wr_ptr_q <= 1'b0;
                    occ_q    <= 2'd0;
                end else begin
                    occ_q <= occ_d;
                    if (push[gi]) begin
                        if (wr_ptr_q) begin
                            ent1_q <= hold_data_q;
                        end else begin
                            ent0_q <= hold_data_q;
                        end
                        wr_ptr_q <= ~wr_ptr_q;
                    end
                    if (pop) begin
                        rd_ptr_q <= ~rd_ptr_q;
                    end
                end
            end

            assign bus.demux_bus_valid_out[gi] = (occ_q != 2'd0);
            assign bus.demux_bus_out[gi]       = rd_ptr_q ? ent1_q : ent0_q;
        end
    endgenerate
endmodule

// File: tb/tb_demux_bus_1_in_n_out.sv
// Bench for demux_bus_1_in_n_out: a queue-based model checks a WIDTH=4 instance
// every cycle; a WIDTH=3 instance with a narrow counter exercises drops and saturation.
module tb_demux_bus_1_in_n_out;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    demux_bus_1_in_n_out_if #(.WIDTH(4)) bus4 ();
    demux_bus_1_in_n_out_if #(.WIDTH(3), .DROP_CNT_WIDTH(4)) bus3 ();

    demux_bus_1_in_n_out #(.WIDTH(4)) u_dut4 (
        .ap_clk   (clk),
        .areset_n (rst_n),
        .bus      (bus4)
    );

    demux_bus_1_in_n_out #(.WIDTH(3), .DROP_CNT_WIDTH(4)) u_dut3 (
        .ap_clk   (clk),
        .areset_n (rst_n),
        .bus      (bus3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model of the WIDTH=4 instance: a pending word plus one queue per port.
    logic [7:0] mq [4][$];
    logic [7:0] dlv1 [$];
    bit         m_hold, m_hb, m_init;
    logic [7:0] m_hd;
    logic [1:0] m_hs;
    int         n_exp = 0;
    int         n_dlv = 0;

    always @(negedge clk) begin : model_chk
        bit         drn, rdy, room_all;
        logic [3:0] exp_v;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            m_hold = 0;
            m_init = 0;
            n_exp  = 0;
            n_dlv  = 0;
        end
        room_all = 1;
        for (int i = 0; i < 4; i++) begin
            if (mq[i].size() >= 2) room_all = 0;
            exp_v[i] = (mq[i].size() != 0);
        end
        drn = m_hold && (m_hb ? room_all : (mq[m_hs].size() < 2));
        rdy = m_init && (!m_hold || drn);
        chk("model_ready", {31'd0, bus4.demux_bus_ready}, {31'd0, rdy});
        chk("model_valid_out", {28'd0, bus4.demux_bus_valid_out}, {28'd0, exp_v});
        for (int i = 0; i < 4; i++) begin
            if (exp_v[i]) chk("model_port_data", {24'd0, bus4.demux_bus_out[i]}, {24'd0, mq[i][0]});
        end
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (bus4.demux_bus_valid_out[i] && bus4.demux_bus_ready_in[i]) begin
                    n_dlv++;
                    if (i == 1) dlv1.push_back(bus4.demux_bus_out[1]);
                end
                if (exp_v[i] && bus4.demux_bus_ready_in[i]) void'(mq[i].pop_front());
            end
            if (drn) begin
                m_hold = 0;
                if (m_hb) begin
                    for (int i = 0; i < 4; i++) mq[i].push_back(m_hd);
                    n_exp += 4;
                end else begin
                    mq[m_hs].push_back(m_hd);
                    n_exp++;
                end
            end
            if (rdy && bus4.demux_bus_valid) begin
                m_hold = 1;
                m_hd   = bus4.demux_bus_in;
                m_hs   = bus4.demux_select;
                m_hb   = bus4.demux_broadcast;
            end
            m_init = 1;
        end
    end

    // Present a word to the WIDTH=4 instance and hold it until the edge that takes it.
    task automatic send4(input logic [7:0] d, input logic [1:0] s, input bit b);
        int t = 0;
        bit done = 0;
        bus4.demux_bus_valid     = 1'b1;
        bus4.demux_bus_in        = d;
        bus4.demux_select        = s;
        bus4.demux_broadcast     = b;
        while (!done) begin
            @(negedge clk);
            done = bus4.demux_bus_ready;
            @(posedge clk);
            #1;
            t++;
            if (!done && t > 500) begin
                chk("send4_timeout", 32'd0, 32'd1);
                done = 1;
            end
        end
        bus4.demux_bus_valid = 1'b0;
        $display("[TB] u4 send data=%02h sel=%0d bcast=%0d", d, s, b);
    endtask

    task automatic send3(input logic [7:0] d, input logic [1:0] s, input bit b);
        int t = 0;
        bit done = 0;
        bus3.demux_bus_valid     = 1'b1;
        bus3.demux_bus_in        = d;
        bus3.demux_select        = s;
        bus3.demux_broadcast     = b;
        while (!done) begin
            @(negedge clk);
            done = bus3.demux_bus_ready;
            @(posedge clk);
            #1;
            t++;
            if (!done && t > 500) begin
                chk("send3_timeout", 32'd0, 32'd1);
                done = 1;
            end
        end
        bus3.demux_bus_valid = 1'b0;
        $display("[TB] u3 send data=%02h sel=%0d bcast=%0d", d, s, b);
    endtask

    logic [7:0] exp33 [4];

    initial begin
        int  sent;
        int  cyc;
        bit  taken;

        rst_n = 1'b0;
        bus4.demux_bus_valid = 1'b0; bus4.demux_bus_in = '0; bus4.demux_select = '0;
        bus4.demux_broadcast = 1'b0; bus4.demux_bus_ready_in = 4'hF;
        bus3.demux_bus_valid = 1'b0; bus3.demux_bus_in = '0; bus3.demux_select = '0;
        bus3.demux_broadcast = 1'b0; bus3.demux_bus_ready_in = 3'h7;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready4", {31'd0, bus4.demux_bus_ready}, 32'd0);
        chk("rst_valid4", {28'd0, bus4.demux_bus_valid_out}, 32'd0);
        chk("rst_drop3", {28'd0, bus3.demux_drop_count}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_ready4", {31'd0, bus4.demux_bus_ready}, 32'd1);
        chk("post_rst_ready3", {31'd0, bus3.demux_bus_ready}, 32'd1);
        @(posedge clk); #1;

        // Single unicast word: one edge from acceptance to valid_out.
        send4(8'hA1, 2'd2, 1'b0);
        @(negedge clk);
        chk("lat_valid_before", {28'd0, bus4.demux_bus_valid_out}, 32'd0);
        @(negedge clk);
        chk("lat_valid_after", {28'd0, bus4.demux_bus_valid_out}, 32'h4);
        chk("lat_data", {24'd0, bus4.demux_bus_out[2]}, 32'hA1);
        @(posedge clk); #1;

        // Port 1 stalled: two words fill its FIFO, the third waits in hold.
        bus4.demux_bus_ready_in = 4'b1101;
        dlv1.delete();
        send4(8'h11, 2'd1, 1'b0);
        send4(8'h12, 2'd1, 1'b0);
        send4(8'h13, 2'd1, 1'b0);
        @(negedge clk);
        chk("stall_ready", {31'd0, bus4.demux_bus_ready}, 32'd0);
        chk("stall_valid", {28'd0, bus4.demux_bus_valid_out}, 32'h2);
        chk("stall_head", {24'd0, bus4.demux_bus_out[1]}, 32'h11);
        @(posedge clk); #1;
        bus4.demux_bus_ready_in = 4'hF;
        send4(8'h14, 2'd1, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("stall_count", dlv1.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < dlv1.size()) chk("stall_order", {24'd0, dlv1[i]}, 32'h11 + i);
        end

        // Broadcast blocked by a full FIFO[3], released when it pops.
        bus4.demux_bus_ready_in = 4'b0111;
        send4(8'h31, 2'd3, 1'b0);
        send4(8'h32, 2'd3, 1'b0);
        send4(8'h5C, 2'd0, 1'b1);
        @(negedge clk);
        chk("bc_block_ready", {31'd0, bus4.demux_bus_ready}, 32'd0);
        chk("bc_block_valid", {28'd0, bus4.demux_bus_valid_out}, 32'h8);
        @(posedge clk); #1;
        bus4.demux_bus_ready_in = 4'hF;
        @(negedge clk);
        chk("bc_pop_gap_ready", {31'd0, bus4.demux_bus_ready}, 32'd0);
        chk("bc_pop_gap_head", {24'd0, bus4.demux_bus_out[3]}, 32'h31);
        @(negedge clk);
        chk("bc_second_head", {24'd0, bus4.demux_bus_out[3]}, 32'h32);
        chk("bc_second_valid", {28'd0, bus4.demux_bus_valid_out}, 32'h8);
        @(negedge clk);
        chk("bc_all_valid", {28'd0, bus4.demux_bus_valid_out}, 32'hF);
        for (int i = 0; i < 4; i++) exp33[i] = 8'h5C;
        for (int i = 0; i < 4; i++) chk("bc_all_data", {24'd0, bus4.demux_bus_out[i]}, {24'd0, exp33[i]});
        @(posedge clk); #1;

        // WIDTH=3: select 3 is dropped and counted; 4-bit counter saturates.
        send3(8'h77, 2'd3, 1'b0);
        @(negedge clk);
        chk("drop_ready", {31'd0, bus3.demux_bus_ready}, 32'd1);
        @(negedge clk);
        chk("drop_count1", {28'd0, bus3.demux_drop_count}, 32'd1);
        chk("drop_no_valid", {29'd0, bus3.demux_bus_valid_out}, 32'd0);
        @(posedge clk); #1;
        bus3.demux_bus_valid = 1'b1;
        bus3.demux_select    = 2'd3;
        bus3.demux_broadcast = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus3.demux_bus_in = 8'(i);
            @(negedge clk);
            chk("drop_burst_ready", {31'd0, bus3.demux_bus_ready}, 32'd1);
            @(posedge clk); #1;
        end
        bus3.demux_bus_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("drop_saturate", {28'd0, bus3.demux_drop_count}, 32'hF);
        chk("drop_sat_no_valid", {29'd0, bus3.demux_bus_valid_out}, 32'd0);
        @(posedge clk); #1;
        send3(8'h88, 2'd3, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("bc3_valid", {29'd0, bus3.demux_bus_valid_out}, 32'h7);
        chk("bc3_data0", {24'd0, bus3.demux_bus_out[0]}, 32'h88);
        chk("bc3_data2", {24'd0, bus3.demux_bus_out[2]}, 32'h88);
        chk("bc3_drop_same", {28'd0, bus3.demux_drop_count}, 32'hF);
        @(posedge clk); #1;

        // Reset with two words in FIFO[0] and one in hold.
        bus4.demux_bus_ready_in = 4'b1110;
        send4(8'h41, 2'd0, 1'b0);
        send4(8'h42, 2'd0, 1'b0);
        send4(8'h43, 2'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", {31'd0, bus4.demux_bus_ready}, 32'd0);
        chk("arst_valid", {28'd0, bus4.demux_bus_valid_out}, 32'd0);
        chk("arst_data0", {24'd0, bus4.demux_bus_out[0]}, 32'd0);
        chk("arst_drop3", {28'd0, bus3.demux_drop_count}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus4.demux_bus_ready_in = 4'hF;
        @(posedge clk); #1;
        @(negedge clk);
        chk("arst_release_ready", {31'd0, bus4.demux_bus_ready}, 32'd1);
        chk("arst_release_valid", {28'd0, bus4.demux_bus_valid_out}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("arst_no_ghost", {28'd0, bus4.demux_bus_valid_out}, 32'd0);

        // Random traffic: 10k words, random selects/broadcasts, random backpressure.
        sent  = 0;
        cyc   = 0;
        taken = 0;
        while (sent < 10000 && cyc < 60000) begin
            if (!bus4.demux_bus_valid || taken) begin
                if ($urandom_range(3) != 0) begin
                    bus4.demux_bus_valid = 1'b1;
                    bus4.demux_bus_in    = 8'($urandom);
                    bus4.demux_select    = 2'($urandom);
                    bus4.demux_broadcast = ($urandom_range(7) == 0);
                end else begin
                    bus4.demux_bus_valid = 1'b0;
                end
            end
            if (((cyc / 400) % 4) == 3)
                bus4.demux_bus_ready_in = 4'($urandom) & 4'b1010;
            else
                bus4.demux_bus_ready_in = 4'($urandom) | 4'($urandom);
            @(negedge clk);
            taken = bus4.demux_bus_valid && bus4.demux_bus_ready;
            if (taken) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("random_words_sent", sent, 32'd10000);
        bus4.demux_bus_valid    = 1'b0;
        bus4.demux_bus_ready_in = 4'hF;
        repeat (10) @(posedge clk);
        #1;
        chk("random_drained", {28'd0, bus4.demux_bus_valid_out}, 32'd0);
        chk("random_no_loss_dup", n_dlv, n_exp);
        chk("u4_never_drops", {16'd0, bus4.demux_drop_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
